overture_regfile: RTL and testbench
===================================

Name: overture_regfile

Overview:
Register file and I/O stage for the Overture 8-bit datapath.
- Holds REG0-REG5 and exposes the selected source byte on rd_data; this is the copy/ALU operand path that the downstream 2:1 byte muxes choose between.
- Provides a valid/ready input port (source 6) and a one-entry buffered valid/ready output port (destination 6).
- Raises stall while an I/O transfer cannot complete, so the sequencer holds the instruction.

Parameters:
WIDTH, 8, data width of every register and port
NUM_REGS, 6, number of general registers, indices 0..NUM_REGS-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
rd_en  input  1  instruction reads rd_src this cycle
rd_src  input  3  source select: 0-5 = REGn, 6 = input port, 7 = constant zero
wr_en  input  1  instruction writes wr_dst this cycle
wr_dst  input  3  destination select: 0-5 = REGn, 6 = output port, 7 = discard
wr_data  input  8  byte to write
rd_data  output  8  selected source byte (combinational)
reg0  output  8  REG0 tap (immediate/branch target)
reg1  output  8  REG1 tap (ALU operand A)
reg2  output  8  REG2 tap (ALU operand B)
reg3  output  8  REG3 tap (condition input)
in_data  input  8  input port byte
in_valid  input  1  in_data valid
in_ready  output  1  input byte consumed this cycle
out_data  output  8  output buffer byte
out_valid  output  1  output buffer full
out_ready  input  1  consumer accepts out_data
stall  output  1  instruction cannot complete this cycle

Behaviour:
- Reset (rst=1 at clk edge): REG0-REG5 = 0x00, out_data = 0x00, out_valid = 0. rst overrides every write and transfer in that cycle. A mid-transfer reset drops any buffered output byte.
- rd_data is combinational and has zero latency:
  - REGn (rd_src 0-5) returns the value before this edge; there is no write-to-read bypass.
  - rd_src 6 returns in_data.
  - rd_src 7 returns 0x00.
  - rd_data is don't-care when rd_en=0; a constant 0x00 is acceptable.
- in_stall = rd_en & (rd_src==6) & ~in_valid.
- out_blocked = out_valid & ~out_ready.
- out_stall = wr_en & (wr_dst==6) & out_blocked.
- stall = in_stall | out_stall, combinational.
- commit = ~stall.
- in_ready = rd_en & (rd_src==6) & in_valid & ~out_stall. The byte is consumed only when the whole instruction commits, so a stalled instruction never loses an input byte.
- Register write: if wr_en & commit & wr_dst<6, REG[wr_dst] <= wr_data at the edge. A write is visible on rd_data and the taps one cycle later.
- Output buffer, next state per cycle:
  - write = wr_en & commit & (wr_dst==6).
  - If write: out_data <= wr_data and out_valid <= 1. This includes the case where the buffer is full and out_ready=1 in the same cycle: the old byte drains and the new one loads, with no bubble.
  - Else if out_valid & out_ready: out_valid <= 0, and out_data holds its value.
  - Else: hold.
- wr_dst 7: the write is discarded and never stalls.
- rd_src 7 never stalls.
- Stall on both sides (in_stall and out_stall together): stall=1 and in_ready=0. Nothing changes state except a drain from the output buffer.
- There is no state machine beyond the output-buffer full flag, which has two states:
  - EMPTY -> FULL on write.
  - FULL -> EMPTY on drain without write.
  - FULL -> FULL on write, or when not drained.
- The taps reg0-reg3 always reflect the current register state and are not gated by stall.

Decomposition:
- Package overture_pkg holds:
  - OV_WIDTH = 8, OV_NUM_REGS = 6.
  - OV_SEL_IO = 3'd6, OV_SEL_NONE = 3'd7.
  - typedef ov_byte_t (logic [7:0]) and typedef ov_sel_t (logic [2:0]).
- One sub-module, overture_out_buf: the one-entry valid/ready output buffer with load/drain logic. It takes clk and rst, load and load_data as inputs, and drives out_data and out_valid, with out_ready as an input.
- The register array, read select and stall logic stay in overture_regfile.

Test Plan:
- Reset with rst=1 for 2 cycles, then wr_en=1 to REG3 with data 0x5A -> during reset all taps and out_valid are 0. One cycle after the write, reg3=0x5A and rd_src=3 returns 0x5A.
- Same-cycle read and write of REG2 (old 0x11, write 0x22) -> rd_data=0x11 that cycle and 0x22 the next.
- rd_src=6, wr_dst=1, in_valid=0 for 3 cycles, then in_data=0xA7 with in_valid=1 -> stall=1 and in_ready=0 for 3 cycles, REG1 unchanged. In cycle 4: stall=0, in_ready=1 for exactly 1 cycle, and REG1=0xA7 afterwards.
- Write 0x3C to dst 6 with out_ready=0, then write 0x4D to dst 6 -> out_valid=1 and out_data=0x3C. The second write stalls until out_ready=1; in that cycle 0x3C drains and 0x4D loads with out_valid staying 1.
- rd_src=6 (in_valid=1) with wr_dst=6 while the buffer is full and out_ready=0 -> stall=1 and in_ready=0, nothing is consumed. When out_ready=1, the instruction commits and out_data = the in_data value.
- rd_src=7 with wr_dst=7 and wr_data=0xFF -> rd_data=0x00, stall=0, and no register or output change.

Source files
------------

// File: rtl/overture_pkg.sv
// Overture shared definitions: datapath width, register count, select codes
// and the byte/select types used by the register file and its I/O stage.
package overture_pkg;

  localparam int OV_WIDTH    = 8;
  localparam int OV_NUM_REGS = 6;

  localparam logic [2:0] OV_SEL_IO   = 3'd6;  // input port (src) / output port (dst)
  localparam logic [2:0] OV_SEL_NONE = 3'd7;  // constant zero (src) / discard (dst)

  typedef logic [OV_WIDTH-1:0] ov_byte_t;
  typedef logic [2:0]          ov_sel_t;

endpackage

// File: rtl/overture_regfile_if.sv
// Overture register-file bus: instruction read/write controls, register taps,
// input-port and output-port valid/ready handshakes, and the stall flag.
//   master : sequencer / environment side (drives selects, data, in_*, out_ready)
//   slave  : register file side (drives rd_data, taps, in_ready, out_*, stall)
interface overture_regfile_if;
  import overture_pkg::*;

  logic     rd_en;
  ov_sel_t  rd_src;
  logic     wr_en;
  ov_sel_t  wr_dst;
  ov_byte_t wr_data;
  ov_byte_t rd_data;
  ov_byte_t reg0;
  ov_byte_t reg1;
  ov_byte_t reg2;
  ov_byte_t reg3;
  ov_byte_t in_data;
  logic     in_valid;
  logic     in_ready;
  ov_byte_t out_data;
  logic     out_valid;
  logic     out_ready;
  logic     stall;

  modport master (
    output rd_en, rd_src, wr_en, wr_dst, wr_data, in_data, in_valid, out_ready,
    input  rd_data, reg0, reg1, reg2, reg3, in_ready, out_data, out_valid, stall
  );

  modport slave (
    input  rd_en, rd_src, wr_en, wr_dst, wr_data, in_data, in_valid, out_ready,
    output rd_data, reg0, reg1, reg2, reg3, in_ready, out_data, out_valid, stall
  );

endinterface

// File: rtl/overture_out_buf.sv
// One-entry valid/ready output buffer for destination 6.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   load       : committed write to the output port this cycle
//   load_data  : byte to load
//   out_ready  : consumer accepts out_data
//   out_data   : buffered byte
//   out_valid  : buffer full
module overture_out_buf
  import overture_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  ov_byte_t load_data,
  input  logic     out_ready,
  output ov_byte_t out_data,
  output logic     out_valid
);

  ov_byte_t out_data_d, out_data_q;
  logic     out_valid_d, out_valid_q;

  // A load while full with out_ready=1 drains the old byte and loads the new
  // one in the same cycle, so load takes priority over the drain.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_data_d  = load_data;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/overture_regfile.sv
// Overture register file and I/O stage: REG0-REG5, combinational source
// select, input port (source 6), buffered output port (destination 6) and
// the stall flag that holds the instruction while an I/O transfer is blocked.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : overture_regfile_if.slave (selects, data, taps, handshakes, stall)
module overture_regfile
  import overture_pkg::*;
#(
  parameter int WIDTH    = OV_WIDTH,
  parameter int NUM_REGS = OV_NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  overture_regfile_if.slave   bus
);

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];

  logic     rd_io, wr_io;
  logic     in_stall, out_stall, out_blocked, stall_c, commit;
  logic     reg_we, out_load;
  ov_byte_t rd_data_c;
  ov_byte_t out_data_w;
  logic     out_valid_w;

  assign rd_io = bus.rd_en && (bus.rd_src == OV_SEL_IO);
  assign wr_io = bus.wr_en && (bus.wr_dst == OV_SEL_IO);

  assign in_stall    = rd_io && !bus.in_valid;
  assign out_blocked = out_valid_w && !bus.out_ready;
  assign out_stall   = wr_io && out_blocked;
  assign stall_c     = in_stall || out_stall;
  assign commit      = !stall_c;

  // Consume the input byte only when the whole instruction commits.
  assign bus.in_ready = rd_io && bus.in_valid && !out_stall;

  assign reg_we   = bus.wr_en && commit;
  assign out_load = wr_io && commit;

  // Reads see the pre-edge register value; no write-to-read bypass.
  always_comb begin
    rd_data_c = '0;
    if (bus.rd_en) begin
      if (bus.rd_src == OV_SEL_IO) begin
        rd_data_c = bus.in_data;
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (bus.rd_src == ov_sel_t'(i)) rd_data_c = regs_q[i];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (reg_we && (bus.wr_dst == ov_sel_t'(i))) regs_d[i] = bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  overture_out_buf u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (out_load),
    .load_data (bus.wr_data),
    .out_ready (bus.out_ready),
    .out_data  (out_data_w),
    .out_valid (out_valid_w)
  );

  assign bus.rd_data   = rd_data_c;
  assign bus.stall     = stall_c;
  assign bus.out_data  = out_data_w;
  assign bus.out_valid = out_valid_w;
  assign bus.reg0      = regs_q[0];
  assign bus.reg1      = regs_q[1];
  assign bus.reg2      = regs_q[2];
  assign bus.reg3      = regs_q[3];

endmodule

// File: tb/tb_overture_regfile.sv
module tb_overture_regfile;
  import overture_pkg::*;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  ov_byte_t exp_q [$];

  overture_regfile_if bus ();

  overture_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input ov_byte_t obs, input ov_byte_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare a draining output byte against the oldest queued expectation.
  task automatic pop_check(input string tag, input ov_byte_t obs);
    ov_byte_t e;
    n_tests++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected <queued byte>", tag, obs);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  task automatic idle();
    bus.rd_en     = 1'b0;
    bus.rd_src    = 3'd0;
    bus.wr_en     = 1'b0;
    bus.wr_dst    = OV_SEL_NONE;
    bus.wr_data   = 8'h00;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // Inputs change 1 time unit after the edge; checks happen 3 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    next_cycle();
    next_cycle();
    settle();
    check("rst_reg0", bus.reg0, 8'h00);
    check("rst_reg1", bus.reg1, 8'h00);
    check("rst_reg2", bus.reg2, 8'h00);
    check("rst_reg3", bus.reg3, 8'h00);
    check("rst_out_valid", {7'd0, bus.out_valid}, 8'h00);
    check("rst_out_data", bus.out_data, 8'h00);

    // Write REG3 = 5A, read back next cycle
    rst = 1'b0;
    bus.wr_en = 1'b1; bus.wr_dst = 3'd3; bus.wr_data = 8'h5A;
    settle();
    check("wr3_stall", {7'd0, bus.stall}, 8'h00);
    next_cycle();
    idle();
    bus.rd_en = 1'b1; bus.rd_src = 3'd3;
    settle();
    check("reg3_tap", bus.reg3, 8'h5A);
    check("reg3_rd", bus.rd_data, 8'h5A);

    // REG2 = 11, then same-cycle read old / write new
    next_cycle();
    idle();
    bus.wr_en = 1'b1; bus.wr_dst = 3'd2; bus.wr_data = 8'h11;
    next_cycle();
    bus.rd_en = 1'b1; bus.rd_src = 3'd2; bus.wr_data = 8'h22;
    settle();
    check("rw2_old", bus.rd_data, 8'h11);
    next_cycle();
    idle();
    bus.rd_en = 1'b1; bus.rd_src = 3'd2;
    settle();
    check("rw2_new", bus.rd_data, 8'h22);
    check("rw2_tap", bus.reg2, 8'h22);

    // Input stall: src 6 -> REG1 with no valid input for 3 cycles
    next_cycle();
    idle();
    bus.rd_en = 1'b1; bus.rd_src = OV_SEL_IO;
    bus.wr_en = 1'b1; bus.wr_dst = 3'd1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("in_stall_%0d", c), {7'd0, bus.stall}, 8'h01);
      check($sformatf("in_ready_lo_%0d", c), {7'd0, bus.in_ready}, 8'h00);
      next_cycle();
      check($sformatf("in_reg1_hold_%0d", c), bus.reg1, 8'h00);
    end
    bus.in_data = 8'hA7; bus.in_valid = 1'b1;
    bus.wr_data = 8'hA7;  // the copy path feeds rd_data back as wr_data
    settle();
    check("in_go_stall", {7'd0, bus.stall}, 8'h00);
    check("in_go_ready", {7'd0, bus.in_ready}, 8'h01);
    check("in_go_rd", bus.rd_data, 8'hA7);
    next_cycle();
    idle();
    settle();
    check("in_done_ready", {7'd0, bus.in_ready}, 8'h00);
    check("in_done_reg1", bus.reg1, 8'hA7);

    // Output buffer: 3C then 4D, second write stalls until out_ready
    next_cycle();
    bus.wr_en = 1'b1; bus.wr_dst = OV_SEL_IO; bus.wr_data = 8'h3C;
    exp_q.push_back(8'h3C);
    settle();
    check("ob_w1_stall", {7'd0, bus.stall}, 8'h00);
    next_cycle();
    bus.wr_data = 8'h4D;
    exp_q.push_back(8'h4D);
    for (int c = 0; c < 2; c++) begin
      settle();
      check($sformatf("ob_full_valid_%0d", c), {7'd0, bus.out_valid}, 8'h01);
      check($sformatf("ob_full_data_%0d", c), bus.out_data, 8'h3C);
      check($sformatf("ob_w2_stall_%0d", c), {7'd0, bus.stall}, 8'h01);
      next_cycle();
    end
    bus.out_ready = 1'b1;
    settle();
    check("ob_swap_stall", {7'd0, bus.stall}, 8'h00);
    pop_check("ob_drain_3c", bus.out_data);
    next_cycle();
    idle();
    settle();
    check("ob_swap_valid", {7'd0, bus.out_valid}, 8'h01);
    check("ob_swap_data", bus.out_data, 8'h4D);

    // Both sides: src 6 -> dst 6 while buffer full and blocked
    next_cycle();
    bus.rd_en = 1'b1; bus.rd_src = OV_SEL_IO;
    bus.in_valid = 1'b1; bus.in_data = 8'hC3;
    bus.wr_en = 1'b1; bus.wr_dst = OV_SEL_IO; bus.wr_data = 8'hC3;
    exp_q.push_back(8'hC3);
    for (int c = 0; c < 2; c++) begin
      settle();
      check($sformatf("both_stall_%0d", c), {7'd0, bus.stall}, 8'h01);
      check($sformatf("both_in_ready_%0d", c), {7'd0, bus.in_ready}, 8'h00);
      check($sformatf("both_hold_%0d", c), bus.out_data, 8'h4D);
      next_cycle();
    end
    bus.out_ready = 1'b1;
    settle();
    check("both_go_stall", {7'd0, bus.stall}, 8'h00);
    check("both_go_in_ready", {7'd0, bus.in_ready}, 8'h01);
    pop_check("ob_drain_4d", bus.out_data);
    next_cycle();
    idle();
    settle();
    check("both_out_data", bus.out_data, 8'hC3);
    check("both_out_valid", {7'd0, bus.out_valid}, 8'h01);
    bus.out_ready = 1'b1;
    settle();
    pop_check("ob_drain_c3", bus.out_data);
    next_cycle();
    idle();
    settle();
    check("ob_empty", {7'd0, bus.out_valid}, 8'h00);

    // Discard dst / zero src never stall or change state, even with a full blocked buffer
    bus.wr_en = 1'b1; bus.wr_dst = OV_SEL_IO; bus.wr_data = 8'h61;
    exp_q.push_back(8'h61);
    next_cycle();
    idle();
    bus.rd_en = 1'b1; bus.rd_src = OV_SEL_NONE;
    bus.wr_en = 1'b1; bus.wr_dst = OV_SEL_NONE; bus.wr_data = 8'hFF;
    settle();
    check("nop_rd", bus.rd_data, 8'h00);
    check("nop_stall", {7'd0, bus.stall}, 8'h00);
    next_cycle();
    idle();
    settle();
    check("nop_reg0", bus.reg0, 8'h00);
    check("nop_reg1", bus.reg1, 8'hA7);
    check("nop_reg2", bus.reg2, 8'h22);
    check("nop_reg3", bus.reg3, 8'h5A);
    check("nop_out_data", bus.out_data, 8'h61);
    check("nop_out_valid", {7'd0, bus.out_valid}, 8'h01);

    // Highest register index
    bus.wr_en = 1'b1; bus.wr_dst = 3'd5; bus.wr_data = 8'hE1;
    next_cycle();
    idle();
    bus.rd_en = 1'b1; bus.rd_src = 3'd5;
    settle();
    check("reg5_rd", bus.rd_data, 8'hE1);

    // Reset with a buffered byte drops it and clears registers
    next_cycle();
    idle();
    rst = 1'b1;
    bus.wr_en = 1'b1; bus.wr_dst = 3'd0; bus.wr_data = 8'h77;
    next_cycle();
    rst = 1'b0;
    idle();
    exp_q.delete();
    bus.rd_en = 1'b1; bus.rd_src = 3'd5;
    settle();
    check("rst2_out_valid", {7'd0, bus.out_valid}, 8'h00);
    check("rst2_reg0", bus.reg0, 8'h00);
    check("rst2_reg3", bus.reg3, 8'h00);
    check("rst2_reg5", bus.rd_data, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish, expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
